// File: rtl/board_io_ctrl.sv
// board_io_ctrl: conditions raw board inputs (two-flop synchroniser, per-channel
// debounce, one-cycle rise/fall pulses) and drives LEDs in off, direct, blink or
// PWM-dim mode from a shared free-running timebase.
module board_io_ctrl #(
    parameter int NUM_IN            = 8,
    parameter int NUM_LED           = 4,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int BLINK_HALF_CYCLES = 12500000,
    parameter int PWM_BITS          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            pin_in,
    output logic [NUM_IN-1:0]            in_level,
    output logic [NUM_IN-1:0]            in_rise,
    output logic [NUM_IN-1:0]            in_fall,
    input  logic [NUM_LED-1:0]           led_in,
    input  logic [2*NUM_LED-1:0]         led_mode,
    input  logic [PWM_BITS*NUM_LED-1:0]  led_duty,
    output logic [NUM_LED-1:0]           led_out
);

    // Debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Blink prescaler counts 0..BLINK_HALF_CYCLES-1; keep at least one bit so
    // a half-period of one cycle still yields a legal vector.
    localparam int              BL_W    = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_DIRECT = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_PWM    = 2'b11
    } led_mode_t;

    logic [NUM_IN-1:0]   sync_meta;
    logic [NUM_IN-1:0]   sync_q;
    logic [DB_W-1:0]     db_cnt      [NUM_IN];
    logic [DB_W-1:0]     db_cnt_next [NUM_IN];
    logic [NUM_IN-1:0]   level_next;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BL_W-1:0]     blink_cnt;
    logic                blink_phase;
    logic [NUM_LED-1:0]  led_next;

    // Two-flop synchroniser per input pin, nothing between the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= pin_in;
            sync_q    <= sync_meta;
        end
    end

    // Per-channel debounce decision: count consecutive disagreeing samples and
    // adopt the new level once enough have been seen; any agreement restarts.
    always_comb begin
        level_next = in_level;
        for (int i = 0; i < NUM_IN; i++) begin
            db_cnt_next[i] = '0;
            if (sync_q[i] != in_level[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    level_next[i] = sync_q[i];
                end else begin
                    db_cnt_next[i] = db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Debounce state plus edge pulses, registered together so each pulse
    // lines up with the first cycle the new level is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                db_cnt[i] <= '0;
            end
            in_level <= '0;
            in_rise  <= '0;
            in_fall  <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                db_cnt[i] <= db_cnt_next[i];
            end
            in_level <= level_next;
            in_rise  <= level_next & ~in_level;
            in_fall  <= ~level_next & in_level;
        end
    end

    // Shared LED timebase: free-running PWM counter and blink prescaler whose
    // wrap toggles the blink phase. Never disturbed by mode or duty changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (blink_cnt == BL_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BL_W'(1);
            end
        end
    end

    // Per-LED output selection from mode, data bit, blink phase and duty.
    always_comb begin
        led_next = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (led_mode_t'(led_mode[2*i +: 2]))
                MODE_OFF:    led_next[i] = 1'b0;
                MODE_DIRECT: led_next[i] = led_in[i];
                MODE_BLINK:  led_next[i] = led_in[i] & blink_phase;
                MODE_PWM:    led_next[i] = (pwm_cnt < led_duty[PWM_BITS*i +: PWM_BITS]);
                default:     led_next[i] = 1'b0;
            endcase
        end
    end

    // Registered LED drive so pins never see combinational glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= '0;
        end else begin
            led_out <= led_next;
        end
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed checks of debounce, edge pulses, LED modes, PWM
// and mid-operation reset with small timing parameters.
module tb_board_io_ctrl;

    localparam int NUM_IN  = 8;
    localparam int NUM_LED = 4;
    localparam int DB      = 4;
    localparam int BH      = 8;
    localparam int PB      = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_IN-1:0]       pin_in;
    logic [NUM_IN-1:0]       in_level;
    logic [NUM_IN-1:0]       in_rise;
    logic [NUM_IN-1:0]       in_fall;
    logic [NUM_LED-1:0]      led_in;
    logic [2*NUM_LED-1:0]    led_mode;
    logic [PB*NUM_LED-1:0]   led_duty;
    logic [NUM_LED-1:0]      led_out;

    int n_checks = 0;
    int n_fails  = 0;
    int edge_cnt;

    board_io_ctrl #(
        .NUM_IN(NUM_IN), .NUM_LED(NUM_LED), .DEBOUNCE_CYCLES(DB),
        .BLINK_HALF_CYCLES(BH), .PWM_BITS(PB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .in_level(in_level),
        .in_rise(in_rise), .in_fall(in_fall), .led_in(led_in),
        .led_mode(led_mode), .led_duty(led_duty), .led_out(led_out)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Rising edges since reset release: after edge k the timebase has advanced k times.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Advance n rising edges and land on the following falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        pin_in   = '0;
        led_in   = 4'hF;
        led_mode = 8'b01_01_01_01;
        led_duty = '0;
        rst_n    = 1'b0;
        #12;
        n_checks++; if (in_level !== 8'h00) begin n_fails++; $display("[TB] FAIL reset_level: got %h expected %h", in_level, 8'h00); end
        n_checks++; if (in_rise !== 8'h00 || in_fall !== 8'h00) begin n_fails++; $display("[TB] FAIL reset_pulses: got rise %h fall %h expected 00 00", in_rise, in_fall); end
        n_checks++; if (led_out !== 4'h0) begin n_fails++; $display("[TB] FAIL reset_led: got %h expected %h", led_out, 4'h0); end
        led_mode = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        n_checks++; if (in_level !== 8'h00 || in_rise !== 8'h00 || in_fall !== 8'h00) begin n_fails++; $display("[TB] FAIL release_quiet: got level %h rise %h fall %h expected 00 00 00", in_level, in_rise, in_fall); end
    endtask

    task automatic test_clean_press;
        pin_in[0] = 1'b1;
        tick(5);
        n_checks++; if (in_level !== 8'h00) begin n_fails++; $display("[TB] FAIL press_early: got %h expected %h", in_level, 8'h00); end
        tick(1);
        n_checks++; if (in_level !== 8'h01) begin n_fails++; $display("[TB] FAIL press_level: got %h expected %h", in_level, 8'h01); end
        n_checks++; if (in_rise !== 8'h01 || in_fall !== 8'h00) begin n_fails++; $display("[TB] FAIL press_rise: got rise %h fall %h expected 01 00", in_rise, in_fall); end
        tick(1);
        n_checks++; if (in_rise !== 8'h00 || in_level !== 8'h01) begin n_fails++; $display("[TB] FAIL press_one_shot: got rise %h level %h expected 00 01", in_rise, in_level); end
        pin_in[0] = 1'b0;
        tick(5);
        n_checks++; if (in_level !== 8'h01 || in_fall !== 8'h00) begin n_fails++; $display("[TB] FAIL release_early: got level %h fall %h expected 01 00", in_level, in_fall); end
        tick(1);
        n_checks++; if (in_level !== 8'h00 || in_fall !== 8'h01 || in_rise !== 8'h00) begin n_fails++; $display("[TB] FAIL release_fall: got level %h fall %h rise %h expected 00 01 00", in_level, in_fall, in_rise); end
        tick(1);
        n_checks++; if (in_fall !== 8'h00) begin n_fails++; $display("[TB] FAIL release_one_shot: got %h expected %h", in_fall, 8'h00); end
    endtask

    task automatic test_bounce;
        int rises;
        rises = 0;
        for (int w = 0; w < 4; w++) begin
            pin_in[1] = (w % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                tick(1);
                rises += int'(in_rise[1]);
                n_checks++; if (in_level !== 8'h00 || in_fall !== 8'h00) begin n_fails++; $display("[TB] FAIL bounce_hold w%0d c%0d: got level %h fall %h expected 00 00", w, c, in_level, in_fall); end
            end
        end
        pin_in[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            rises += int'(in_rise[1]);
            n_checks++; if (in_level !== 8'h00) begin n_fails++; $display("[TB] FAIL bounce_settle c%0d: got %h expected %h", c, in_level, 8'h00); end
        end
        tick(1);
        rises += int'(in_rise[1]);
        n_checks++; if (in_level !== 8'h02 || in_rise !== 8'h02) begin n_fails++; $display("[TB] FAIL bounce_level: got level %h rise %h expected 02 02", in_level, in_rise); end
        tick(1);
        rises += int'(in_rise[1]);
        n_checks++; if (rises !== 1) begin n_fails++; $display("[TB] FAIL bounce_rise_count: got %0d expected 1", rises); end
    endtask

    task automatic test_multi_channel;
        pin_in = '0;
        tick(8);
        n_checks++; if (in_level !== 8'h00) begin n_fails++; $display("[TB] FAIL multi_clear: got %h expected %h", in_level, 8'h00); end
        pin_in = 8'hFF;
        tick(5);
        n_checks++; if (in_level !== 8'h00 || in_rise !== 8'h00) begin n_fails++; $display("[TB] FAIL multi_early: got level %h rise %h expected 00 00", in_level, in_rise); end
        tick(1);
        n_checks++; if (in_level !== 8'hFF || in_rise !== 8'hFF || in_fall !== 8'h00) begin n_fails++; $display("[TB] FAIL multi_rise: got level %h rise %h fall %h expected ff ff 00", in_level, in_rise, in_fall); end
        tick(1);
        n_checks++; if (in_rise !== 8'h00) begin n_fails++; $display("[TB] FAIL multi_one_shot: got %h expected %h", in_rise, 8'h00); end
    endtask

    task automatic test_led_modes;
        logic exp_blink;
        led_in   = 4'hF;
        led_mode = 8'b00_00_00_01;
        tick(1);
        n_checks++; if (led_out !== 4'b0001) begin n_fails++; $display("[TB] FAIL direct_on: got %b expected %b", led_out, 4'b0001); end
        led_in[0] = 1'b0;
        tick(1);
        n_checks++; if (led_out !== 4'b0000) begin n_fails++; $display("[TB] FAIL direct_data: got %b expected %b", led_out, 4'b0000); end
        led_in   = 4'hF;
        led_mode = 8'b00_10_00_01;
        tick(1);
        for (int c = 0; c < 32; c++) begin
            tick(1);
            exp_blink = (((edge_cnt - 1) / BH) % 2) == 1;
            n_checks++; if (led_out !== {1'b0, exp_blink, 2'b01}) begin n_fails++; $display("[TB] FAIL blink edge%0d: got %b expected %b", edge_cnt, led_out, {1'b0, exp_blink, 2'b01}); end
        end
        led_mode = '0;
        tick(1);
        n_checks++; if (led_out !== 4'b0000) begin n_fails++; $display("[TB] FAIL mode_off: got %b expected %b", led_out, 4'b0000); end
    endtask

    task automatic test_pwm;
        int duties [3] = '{0, 5, 15};
        int highs;
        logic exp_pwm;
        led_mode = 8'b11_00_00_00;
        foreach (duties[d]) begin
            led_duty[15:12] = 4'(duties[d]);
            tick(1);
            highs = 0;
            for (int c = 0; c < 16; c++) begin
                tick(1);
                highs += int'(led_out[3]);
                exp_pwm = ((edge_cnt - 1) % 16) < duties[d];
                n_checks++; if (led_out !== {exp_pwm, 3'b000}) begin n_fails++; $display("[TB] FAIL pwm_d%0d edge%0d: got %b expected %b", duties[d], edge_cnt, led_out, {exp_pwm, 3'b000}); end
            end
            n_checks++; if (highs !== duties[d]) begin n_fails++; $display("[TB] FAIL pwm_count_d%0d: got %0d expected %0d", duties[d], highs, duties[d]); end
        end
        led_duty[15:12] = 4'd5;
        tick(1);
        for (int c = 0; c < 16 && (edge_cnt % 16) != 6; c++) tick(1);
        n_checks++; if ((edge_cnt % 16) !== 6) begin n_fails++; $display("[TB] FAIL pwm_align: got %0d expected 6", edge_cnt % 16); end
        led_duty[15:12] = 4'd10;
        tick(1);
        n_checks++; if (led_out !== 4'b1000) begin n_fails++; $display("[TB] FAIL pwm_change_next_edge: got %b expected %b", led_out, 4'b1000); end
        highs = 0;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            highs += int'(led_out[3]);
            exp_pwm = ((edge_cnt - 1) % 16) < 10;
            n_checks++; if (led_out !== {exp_pwm, 3'b000}) begin n_fails++; $display("[TB] FAIL pwm_d10 edge%0d: got %b expected %b", edge_cnt, led_out, {exp_pwm, 3'b000}); end
        end
        n_checks++; if (highs !== 10) begin n_fails++; $display("[TB] FAIL pwm_count_d10: got %0d expected 10", highs); end
    endtask

    task automatic test_reset_midop;
        int rises;
        pin_in   = 8'hFF;
        led_in   = 4'hF;
        led_mode = 8'b11_00_00_01;
        led_duty = 16'hF000;
        tick(2);
        n_checks++; if (in_level !== 8'hFF || led_out[0] !== 1'b1) begin n_fails++; $display("[TB] FAIL midop_active: got level %h led %b expected ff xxx1", in_level, led_out); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (in_level !== 8'h00 || in_rise !== 8'h00 || in_fall !== 8'h00 || led_out !== 4'h0) begin n_fails++; $display("[TB] FAIL midop_async_clear: got level %h rise %h fall %h led %b expected all zero", in_level, in_rise, in_fall, led_out); end
        led_mode = 8'b00_00_00_01;
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        tick(1);
        rises += $countones(in_rise);
        n_checks++; if (in_level !== 8'h00 || in_rise !== 8'h00 || in_fall !== 8'h00) begin n_fails++; $display("[TB] FAIL midop_no_release_pulse: got level %h rise %h fall %h expected 00 00 00", in_level, in_rise, in_fall); end
        n_checks++; if (led_out !== 4'b0001) begin n_fails++; $display("[TB] FAIL midop_led_resume: got %b expected %b", led_out, 4'b0001); end
        for (int c = 0; c < 4; c++) begin
            tick(1);
            rises += $countones(in_rise);
        end
        n_checks++; if (in_level !== 8'h00) begin n_fails++; $display("[TB] FAIL midop_early: got %h expected %h", in_level, 8'h00); end
        tick(1);
        rises += $countones(in_rise);
        n_checks++; if (in_level !== 8'hFF || in_rise !== 8'hFF) begin n_fails++; $display("[TB] FAIL midop_rise: got level %h rise %h expected ff ff", in_level, in_rise); end
        tick(2);
        rises += $countones(in_rise);
        n_checks++; if (rises !== NUM_IN) begin n_fails++; $display("[TB] FAIL midop_rise_count: got %0d expected %0d", rises, NUM_IN); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_channel();
        test_led_modes();
        test_pwm();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
Parametrised board-level I/O conditioning block that sits between the FPGA pins and the SoC's GPIO, replacing direct pin-to-GPIO wiring.
- Input side: synchronises and debounces NUM_IN asynchronous inputs (buttons, switches) and generates one-cycle rise/fall pulses per channel.
- Output side: drives NUM_LED LEDs, each in a per-LED mode: off, direct, blink or PWM dim.

Parameters:
NUM_IN, 8, number of debounced input channels (>=1)
NUM_LED, 4, number of LED output channels (>=1)
DEBOUNCE_CYCLES, 500000, cycles an input must be stable before the debounced level changes (>=1; 10 ms at 50 MHz)
BLINK_HALF_CYCLES, 12500000, cycles per blink half-period (>=1; 2 Hz blink at 50 MHz)
PWM_BITS, 8, PWM counter and duty width (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pin_in  input  NUM_IN  raw asynchronous pin inputs
in_level  output  NUM_IN  debounced level per channel
in_rise  output  NUM_IN  one-cycle pulse on debounced 0->1
in_fall  output  NUM_IN  one-cycle pulse on debounced 1->0
led_in  input  NUM_LED  per-LED data bit (e.g. from GPIO)
led_mode  input  2*NUM_LED  per-LED mode; LED i uses bits [2i+1:2i]
led_duty  input  PWM_BITS*NUM_LED  per-LED PWM duty; LED i uses slice i
led_out  output  NUM_LED  LED pin drive, registered

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous assert, active-low.
- Reset state: all flops clear to 0. This covers in_level, in_rise, in_fall, led_out, sync stages, debounce counters, PWM counter, blink prescaler and blink_phase.
- Synchroniser: each pin_in bit passes through 2 flops (sync_q). No logic sits between the two stages.
- Debounce, per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync_q == in_level: the counter clears.
  - Else if counter == DEBOUNCE_CYCLES-1: in_level <= sync_q, counter clears.
  - Else: counter increments.
- Debounce latency: a clean pin change is reflected on in_level exactly DEBOUNCE_CYCLES+2 rising edges later.
- Glitch rejection: a pulse or bounce shorter than DEBOUNCE_CYCLES sync samples never changes in_level. Any return to the current level restarts the count from 0.
- DEBOUNCE_CYCLES=1: in_level follows sync_q with 1 cycle of delay and no filtering.
- Edge pulses:
  - in_rise and in_fall are registered and assert for exactly one cycle.
  - That cycle is the first cycle in which the new in_level value is visible.
  - in_rise and in_fall are never both high on the same channel.
- Channel independence: channels are fully independent, and simultaneous changes on several channels are handled in parallel.
- Shared LED timebase:
  - pwm_cnt is a free-running PWM_BITS counter that wraps 2^PWM_BITS-1 -> 0.
  - The blink prescaler counts 0..BLINK_HALF_CYCLES-1. blink_phase toggles on each wrap, starting at 0 after reset.
  - The timebase is not reset by mode or duty changes.
- LED modes (led_out registered, 1-cycle latency from inputs):
  - 00 off: led_out=0.
  - 01 direct: led_out=led_in.
  - 10 blink: led_out=led_in & blink_phase.
  - 11 PWM: led_out=(pwm_cnt < duty).
- PWM boundaries:
  - duty=0 gives constantly 0.
  - duty=2^PWM_BITS-1 gives high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles. This is intentional: full-on uses mode 01.
- Mode or duty change: takes effect on the next clock edge with no glitch beyond the normal registered update.
- Reset mid-operation: all state clears immediately.
  - Inputs held high through reset release reach in_level=1 after DEBOUNCE_CYCLES+2 cycles, and in_rise fires then.
  - No pulse fires at reset release itself.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=8, PWM_BITS=4.
- Clean press: pin_in[0] 0->1 held -> in_level[0]=1 exactly 6 edges later; in_rise[0] high for 1 cycle in that cycle. Release -> in_fall[0] pulse 6 edges after release.
- Bounce: pin_in[1] toggles 1,0,1,0 over 3-cycle windows, then holds 1 -> no in_level change during bounce; in_level[1]=1 six edges after the final stable 1; exactly one in_rise[1].
- Multi-channel: pin_in all channels 0->1 on the same edge -> all in_level bits rise in the same cycle, with NUM_IN simultaneous in_rise pulses.
- LED modes, led_in=1:
  - mode 01 -> led_out=1 one cycle later.
  - mode 10 -> led_out pattern 8 low / 8 high repeating, phase-aligned to the prescaler wrap.
  - mode 00 -> 0.
- PWM: mode 11 with duty 0, 5 and 15 -> led_out high for 0, 5 and 15 of every 16 cycles respectively; duty changed 5->10 mid-period -> new compare used from the next edge.
- Reset mid-op: assert rst_n=0 while pin_in=1, in_level=1 and LEDs active -> all outputs 0 immediately. Release with pin_in still 1 -> in_level=1 and a single in_rise after 6 edges; led_out resumes after 1 cycle.
